// File: rtl/mode_register_bank.sv
// Bank of CHANNELS independent SIZE-bit registers with per-channel opcodes and registered zero/wrap flags.
// Optional snapshot capture of all channels is compiled in with the REG_SNAPSHOT_EN macro.
module mode_register_bank #(
  parameter int              SIZE      = 8,
  parameter int              CHANNELS  = 2,
  parameter logic [SIZE-1:0] RESET_VAL = '0,
  parameter int              SATURATE  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3*CHANNELS-1:0]    op,
  input  logic [SIZE*CHANNELS-1:0] d,
  input  logic [CHANNELS-1:0]      shift_in,
`ifdef REG_SNAPSHOT_EN
  input  logic                     snap,
  output logic [SIZE*CHANNELS-1:0] snap_q,
`endif
  output logic [SIZE*CHANNELS-1:0] q,
  output logic [CHANNELS-1:0]      zero,
  output logic [CHANNELS-1:0]      wrap
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] OP_INC   = 3'b011;
  localparam logic [2:0] OP_DEC   = 3'b100;
  localparam logic [2:0] OP_SHL   = 3'b101;
  localparam logic [2:0] OP_SHR   = 3'b110;

  localparam logic [SIZE-1:0] L_ONE  = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic            L_RST_ZERO = (RESET_VAL == '0);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [2:0]      w_op;
    logic [SIZE-1:0] w_d;
    logic [SIZE-1:0] w_next;
    logic            w_wrap;
    logic [SIZE-1:0] r_q;
    logic            r_zero;
    logic            r_wrap;

    assign w_op = op[3*i +: 3];
    assign w_d  = d[SIZE*i +: SIZE];

    always_comb begin
      w_next = r_q;
      w_wrap = 1'b0;
      case (w_op)
        OP_HOLD:  w_next = r_q;
        OP_LOAD:  w_next = w_d;
        OP_CLEAR: w_next = '0;
        OP_INC: begin
          if (r_q == '1) begin
            w_wrap = 1'b1;
            w_next = (SATURATE != 0) ? r_q : '0;
          end else begin
            w_next = r_q + L_ONE;
          end
        end
        OP_DEC: begin
          if (r_q == '0) begin
            w_wrap = 1'b1;
            w_next = (SATURATE != 0) ? r_q : '1;
          end else begin
            w_next = r_q - L_ONE;
          end
        end
        OP_SHL:  w_next = {r_q[SIZE-2:0], shift_in[i]};
        OP_SHR:  w_next = {shift_in[i], r_q[SIZE-1:1]};
        default: w_next = r_q;
      endcase
    end

    // zero is derived from the next state so it lands in the same cycle as q
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q    <= RESET_VAL;
        r_zero <= L_RST_ZERO;
        r_wrap <= 1'b0;
      end else begin
        r_q    <= w_next;
        r_zero <= (w_next == '0);
        r_wrap <= w_wrap;
      end
    end

    assign q[SIZE*i +: SIZE] = r_q;
    assign zero[i]           = r_zero;
    assign wrap[i]           = r_wrap;
  end

`ifdef REG_SNAPSHOT_EN
  logic [SIZE*CHANNELS-1:0] r_snap_q;

  // q here is still the pre-edge value, so all channels are captured atomically
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap_q <= {CHANNELS{RESET_VAL}};
    end else if (snap) begin
      r_snap_q <= q;
    end
  end

  assign snap_q = r_snap_q;
`endif

endmodule

// File: tb/tb_mode_register_bank.sv
// Directed bench for mode_register_bank: a wrapping instance and a saturating instance share stimulus.
// Define REG_SNAPSHOT_EN to also exercise the snapshot port.
module tb_mode_register_bank;

  logic        clk;
  logic        rst_n;
  logic [5:0]  op;
  logic [15:0] d;
  logic [1:0]  shift_in;
  logic [15:0] q, q_s;
  logic [1:0]  zero, zero_s;
  logic [1:0]  wrap, wrap_s;
`ifdef REG_SNAPSHOT_EN
  logic        snap;
  logic [15:0] snap_q, snap_q_s;
`endif

  int n_vec = 0;
  int n_err = 0;

  mode_register_bank #(.SIZE(8), .CHANNELS(2), .RESET_VAL(8'h00), .SATURATE(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .op(op), .d(d), .shift_in(shift_in),
`ifdef REG_SNAPSHOT_EN
    .snap(snap), .snap_q(snap_q),
`endif
    .q(q), .zero(zero), .wrap(wrap)
  );

  mode_register_bank #(.SIZE(8), .CHANNELS(2), .RESET_VAL(8'h00), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .op(op), .d(d), .shift_in(shift_in),
`ifdef REG_SNAPSHOT_EN
    .snap(snap), .snap_q(snap_q_s),
`endif
    .q(q_s), .zero(zero_s), .wrap(wrap_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; op = 6'o00; d = 16'h0000; shift_in = 2'b00;
`ifdef REG_SNAPSHOT_EN
    snap = 1'b0;
`endif
    step(); step();
    rst_n = 1'b1;
    step(); step();
    n_vec++; if (q !== 16'h0000) begin n_err++; $display("FAIL reset_q got %h exp 0000", q); end
    n_vec++; if (zero !== 2'b11) begin n_err++; $display("FAIL reset_zero got %b exp 11", zero); end
    n_vec++; if (wrap !== 2'b00) begin n_err++; $display("FAIL reset_wrap got %b exp 00", wrap); end
    n_vec++; if (q_s !== 16'h0000 || zero_s !== 2'b11) begin n_err++; $display("FAIL reset_sat got q=%h z=%b exp 0000 11", q_s, zero_s); end
    op = 6'o11; d = 16'h0503;
    step();
    n_vec++; if (q !== 16'h0503) begin n_err++; $display("FAIL load_q got %h exp 0503", q); end
    n_vec++; if (zero !== 2'b00) begin n_err++; $display("FAIL load_zero got %b exp 00", zero); end
  endtask

  task automatic test_dec();
    logic [7:0] exp_q0;
    op = 6'o04;
    for (int k = 0; k < 3; k++) begin
      step();
      exp_q0 = 8'(2 - k);
      n_vec++; if (q[7:0] !== exp_q0) begin n_err++; $display("FAIL dec_q0 step %0d got %h exp %h", k, q[7:0], exp_q0); end
      n_vec++; if (q[15:8] !== 8'h05) begin n_err++; $display("FAIL dec_q1 step %0d got %h exp 05", k, q[15:8]); end
      n_vec++; if (zero[0] !== (k == 2)) begin n_err++; $display("FAIL dec_zero0 step %0d got %b", k, zero[0]); end
      n_vec++; if (wrap !== 2'b00) begin n_err++; $display("FAIL dec_wrap step %0d got %b exp 00", k, wrap); end
    end
  endtask

  task automatic test_wrap();
    op = 6'o01; d = 16'h00FF;
    step();
    n_vec++; if (q[7:0] !== 8'hFF || q_s[7:0] !== 8'hFF) begin n_err++; $display("FAIL wrap_load got %h/%h exp FF", q[7:0], q_s[7:0]); end
    op = 6'o03;
    step();
    n_vec++; if (q[7:0] !== 8'h00 || zero[0] !== 1'b1 || wrap[0] !== 1'b1) begin n_err++; $display("FAIL inc_wrap got q=%h z=%b w=%b exp 00 1 1", q[7:0], zero[0], wrap[0]); end
    n_vec++; if (q_s[7:0] !== 8'hFF || zero_s[0] !== 1'b0 || wrap_s[0] !== 1'b1) begin n_err++; $display("FAIL inc_sat got q=%h z=%b w=%b exp FF 0 1", q_s[7:0], zero_s[0], wrap_s[0]); end
    step();
    n_vec++; if (q[7:0] !== 8'h01 || wrap[0] !== 1'b0 || zero[0] !== 1'b0) begin n_err++; $display("FAIL inc_after_wrap got q=%h w=%b z=%b exp 01 0 0", q[7:0], wrap[0], zero[0]); end
    n_vec++; if (q_s[7:0] !== 8'hFF || wrap_s[0] !== 1'b1) begin n_err++; $display("FAIL sat_b2b got q=%h w=%b exp FF 1", q_s[7:0], wrap_s[0]); end
    op = 6'o00;
    step();
    n_vec++; if (wrap_s !== 2'b00 || wrap !== 2'b00) begin n_err++; $display("FAIL wrap_clear got %b/%b exp 00", wrap, wrap_s); end
    op = 6'o02;
    step();
    n_vec++; if (q[7:0] !== 8'h00 || zero[0] !== 1'b1) begin n_err++; $display("FAIL clear got q=%h z=%b exp 00 1", q[7:0], zero[0]); end
    op = 6'o04;
    step();
    n_vec++; if (q[7:0] !== 8'hFF || wrap[0] !== 1'b1 || zero[0] !== 1'b0) begin n_err++; $display("FAIL dec_wrap got q=%h w=%b z=%b exp FF 1 0", q[7:0], wrap[0], zero[0]); end
    n_vec++; if (q_s[7:0] !== 8'h00 || wrap_s[0] !== 1'b1 || zero_s[0] !== 1'b1) begin n_err++; $display("FAIL dec_sat got q=%h w=%b z=%b exp 00 1 1", q_s[7:0], wrap_s[0], zero_s[0]); end
  endtask

  task automatic test_shift();
    op = 6'o10; d = 16'h8100; shift_in = 2'b00;
    step();
    n_vec++; if (q[15:8] !== 8'h81) begin n_err++; $display("FAIL shift_load got %h exp 81", q[15:8]); end
    op = 6'o50;
    step();
    n_vec++; if (q[15:8] !== 8'h02) begin n_err++; $display("FAIL shl got %h exp 02", q[15:8]); end
    op = 6'o60; shift_in = 2'b10;
    step();
    n_vec++; if (q[15:8] !== 8'h81) begin n_err++; $display("FAIL shr got %h exp 81", q[15:8]); end
    op = 6'o70; shift_in = 2'b00;
    step();
    n_vec++; if (q[15:8] !== 8'h81) begin n_err++; $display("FAIL reserved_hold got %h exp 81", q[15:8]); end
  endtask

  task automatic test_reset_mid();
    op = 6'o01; d = 16'h000F;
    step();
    op = 6'o03;
    step();
    n_vec++; if (q[7:0] !== 8'h10) begin n_err++; $display("FAIL pre_reset_inc got %h exp 10", q[7:0]); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (q !== 16'h0000 || wrap !== 2'b00 || zero !== 2'b11) begin n_err++; $display("FAIL async_reset got q=%h w=%b z=%b exp 0000 00 11", q, wrap, zero); end
    op = 6'o01; d = 16'h0022;
    #1;
    rst_n = 1'b1;
    step();
    n_vec++; if (q !== 16'h0022) begin n_err++; $display("FAIL post_reset_op got %h exp 0022", q); end
  endtask

  task automatic test_independent();
    op = 6'o43;
    step();
    n_vec++; if (q !== 16'hFF23) begin n_err++; $display("FAIL indep_q got %h exp FF23", q); end
    n_vec++; if (wrap !== 2'b10 || zero !== 2'b00) begin n_err++; $display("FAIL indep_flags got w=%b z=%b exp 10 00", wrap, zero); end
  endtask

`ifdef REG_SNAPSHOT_EN
  task automatic test_snapshot();
    n_vec++; if (snap_q !== 16'h0000) begin n_err++; $display("FAIL snap_reset got %h exp 0000", snap_q); end
    op = 6'o11; d = 16'h0503;
    step();
    op = 6'o03; snap = 1'b1;
    step();
    n_vec++; if (snap_q !== 16'h0503 || q !== 16'h0504) begin n_err++; $display("FAIL snap_capture got snap=%h q=%h exp 0503 0504", snap_q, q); end
    snap = 1'b0;
    step();
    n_vec++; if (snap_q !== 16'h0503 || q !== 16'h0505) begin n_err++; $display("FAIL snap_hold got snap=%h q=%h exp 0503 0505", snap_q, q); end
  endtask
`endif

  initial begin
    test_reset();
    test_dec();
    test_wrap();
    test_shift();
    test_reset_mid();
    test_independent();
`ifdef REG_SNAPSHOT_EN
    test_snapshot();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mode_register_bank.md
Name: mode_register_bank

Overview:
- Parametrised successor to the single load-enable register used in the factorial datapath.
- Holds CHANNELS independent SIZE-bit registers. Each register executes its own per-cycle operation: hold, load, clear, increment, decrement, shift left or shift right.
- Each channel also produces registered zero and wrap flags.
- Intended to replace separate counter/accumulator/operand registers; the factorial FSM drives one op field per channel.

Parameters:
- SIZE, 8, width of each channel register (>=2).
- CHANNELS, 2, number of independent registers (>=1).
- RESET_VAL, 0, value of every channel after reset (SIZE bits).
- SATURATE, 0, 0 = INC/DEC wrap modulo 2^SIZE; 1 = INC/DEC clamp at all-ones/zero.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- op  in  3*CHANNELS  per-channel opcode; channel i uses op[3i+2:3i].
- d  in  SIZE*CHANNELS  per-channel load data; channel i uses d[SIZE*i+SIZE-1:SIZE*i].
- shift_in  in  CHANNELS  serial bit inserted on SHL (into LSB) or SHR (into MSB).
- q  out  SIZE*CHANNELS  per-channel register value, same packing as d.
- zero  out  CHANNELS  registered flag: 1 when the channel's q equals 0.
- wrap  out  CHANNELS  one-cycle registered pulse: INC/DEC crossed (or hit, if saturating) the range boundary.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - every q = RESET_VAL;
  - zero[i] = (RESET_VAL==0);
  - wrap = 0.
- Release is synchronous to clk; the first op is sampled on the first rising edge with rst_n=1.
- Opcodes per channel, applied at the rising edge; new q is visible after the edge (1-cycle latency):
  - 000 HOLD: q unchanged.
  - 001 LOAD: q = d slice.
  - 010 CLEAR: q = 0.
  - 011 INC: q = q+1.
  - 100 DEC: q = q-1.
  - 101 SHL: q = {q[SIZE-2:0], shift_in[i]}.
  - 110 SHR: q = {shift_in[i], q[SIZE-1:1]}.
  - 111 reserved: behaves as HOLD.
- Width rules:
  - Arithmetic is unsigned, SIZE bits.
  - SATURATE=0: all-ones INC yields 0 and sets wrap; 0 DEC yields all-ones and sets wrap.
  - SATURATE=1: all-ones INC stays all-ones; 0 DEC stays 0. Wrap pulses on each such clamped attempt.
- wrap[i]:
  - Asserted for exactly the cycle after the boundary op.
  - Cleared on the next edge unless another boundary op occurs; back-to-back boundary ops hold it high.
- zero[i]:
  - Computed from the next-state value and registered together with q, so it is always consistent with q in the same cycle.
- Channels are fully independent. Simultaneous different ops on different channels must not interact.
- Reset asserted mid-operation overrides any op in flight. No partial update is visible.
- No X propagation from unused d/shift_in bits: a channel's d is only sampled on LOAD.

Optional Feature:
- Macro REG_SNAPSHOT_EN.
- Defined:
  - Adds input snap (1 bit) and output snap_q (SIZE*CHANNELS).
  - On a rising edge with snap=1, snap_q captures the pre-edge q of all channels atomically, including channels being modified on that same edge.
  - snap_q resets to RESET_VAL on rst_n=0 and holds otherwise.
- Undefined: snap and snap_q ports do not exist. Core behaviour is identical.

Test Plan:
1. SIZE=8, CHANNELS=2, rst_n=0 then 1, op=HOLD for 2 cycles -> q=0x0000, zero=2'b11, wrap=0. Then LOAD d={8'h05,8'h03} -> next cycle q={05,03}, zero=2'b00.
2. Channel 0 loaded 0x03, DEC 3 cycles while channel 1 HOLDs 0x05 -> ch0 q 2,1,0, zero[0]=1 on the third cycle, ch1 stays 0x05.
3. SATURATE=0: ch0 LOAD 0xFF then INC -> q=0x00, zero[0]=1, wrap[0]=1 for one cycle. SATURATE=1 rerun -> q=0xFF, wrap[0]=1, zero[0]=0.
4. ch1 LOAD 0x81; SHL with shift_in[1]=0 -> 0x02; then SHR with shift_in[1]=1 -> 0x81.
5. ch0 INC in progress at 0x10; assert rst_n=0 between edges -> q immediately =RESET_VAL, wrap=0; next edge after release applies the new op only.
6. With REG_SNAPSHOT_EN: q={05,03}, snap=1 with ch0 INC on the same edge -> snap_q={05,03}, q={05,04}.
